lcb_poll_sched: RTL and testbench

LCB_POLL_SCHED -- requirements
Module: lcb_poll_sched

---
 rtl/lcb_pkg.sv | 21 ++
 rtl/lcb_byte_counter.sv | 43 ++++
 rtl/lcb_poll_sched.sv | 152 +++++++++++++++
 tb/tb_lcb_poll_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcb_pkg.sv
// lcb_pkg: shared state encoding and request-byte format
// for the LCB poll scheduler.
package lcb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_RECV,
    S_GAP,
    S_DONE
  } lcb_state_t;

  localparam logic [2:0] RQ_PREFIX = 3'b101;

  function automatic logic [7:0] rq_byte(
    input logic [4:0] num
  );
    return {RQ_PREFIX, num};
  endfunction

endpackage

// File: rtl/lcb_byte_counter.sv
// lcb_byte_counter: rxValid rising-edge detector and saturating
// response byte counter for the LCB poll scheduler.
module lcb_byte_counter #(
  parameter int CW  = 4,
  parameter int MAX = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_rx_valid,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_nxt
);

  localparam logic [CW-1:0] W_MAX = CW'(MAX);

  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic          w_rise;

  assign w_rise = i_rx_valid & ~r_prev;
  assign o_cnt  = r_cnt;

  // o_cnt_nxt includes this cycle's edge so the scheduler can
  // let a last byte landing on the timeout cycle win.
  always_comb begin
    o_cnt_nxt = r_cnt;
    if (i_en && w_rise && r_cnt != W_MAX)
      o_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_rx_valid;
      r_cnt  <= i_clr ? '0 : o_cnt_nxt;
    end
  end

endmodule

// File: rtl/lcb_poll_sched.sv
// lcb_poll_sched: polls NUM_LCB units per frame with timeouts.
// Define LCB_POLL_RETRY_EN to retry a timed-out unit once.
module lcb_poll_sched
  import lcb_pkg::*;
#(
  parameter int NUM_LCB      = 24,
  parameter int BYTES_PER_RQ = 15,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int GAP_CYC      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       txReady,
  output logic       txStart,
  output logic [7:0] txByte,
  input  logic       rxValid,
  output logic [4:0] LCBrqNumber,
  output logic       busy,
  output logic       frameDone,
  output logic       timeoutErr,
  output logic [7:0] errCnt
);

  localparam int CW = $clog2(BYTES_PER_RQ + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  localparam logic [CW-1:0] W_FULL   = CW'(BYTES_PER_RQ);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [4:0]    NUM_LAST = 5'(NUM_LCB - 1);

  lcb_state_t    r_state;
  lcb_state_t    w_next;
  logic [4:0]    r_num;
  logic [TW-1:0] r_timer;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_err_cnt;

  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_rx_done;
  logic          w_to;
  logic          w_retry_go;
  logic          w_gap_end;
  logic          w_last;

  lcb_byte_counter #(
    .CW  (CW),
    .MAX (BYTES_PER_RQ)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (r_state == S_SEND),
    .i_en       (r_state == S_RECV),
    .i_rx_valid (rxValid),
    .o_cnt      (w_cnt),
    .o_cnt_nxt  (w_cnt_nxt)
  );

  assign w_rx_done = (w_cnt == W_FULL) && !rxValid;
  assign w_to      = (r_state == S_RECV) && (r_timer == TO_LAST)
                  && (w_cnt_nxt != W_FULL);
  assign w_gap_end = (r_gap == GAP_LAST);
  assign w_last    = (r_num == NUM_LAST);

`ifdef LCB_POLL_RETRY_EN
  logic r_retry;

  assign w_retry_go = w_to & ~r_retry;

  always_ff @(posedge clk) begin
    if (reset)
      r_retry <= 1'b0;
    else if (w_retry_go)
      r_retry <= 1'b1;
    else if (r_state == S_GAP || r_state == S_IDLE)
      r_retry <= 1'b0;
  end
`else
  assign w_retry_go = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    txStart    = 1'b0;
    txByte     = 8'h00;
    busy       = 1'b0;
    frameDone  = 1'b0;
    timeoutErr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_SEND;
      end
      S_SEND: begin
        busy   = 1'b1;
        txByte = rq_byte(r_num);
        if (txReady) begin
          txStart = 1'b1;
          w_next  = S_RECV;
        end
      end
      S_RECV: begin
        busy = 1'b1;
        if (w_rx_done) begin
          w_next = S_GAP;
        end else if (w_retry_go) begin
          w_next = S_SEND;
        end else if (w_to) begin
          timeoutErr = 1'b1;
          w_next     = S_GAP;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (w_gap_end)
          w_next = w_last ? S_DONE : S_SEND;
      end
      S_DONE: begin
        frameDone = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_num     <= '0;
      r_timer   <= '0;
      r_gap     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start)
        r_num <= '0;
      else if (r_state == S_GAP && w_gap_end && !w_last)
        r_num <= r_num + 1'b1;
      r_timer <= (r_state == S_RECV) ? r_timer + 1'b1 : '0;
      r_gap   <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
      if (timeoutErr && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign LCBrqNumber = r_num;
  assign errCnt      = r_err_cnt;

endmodule

// File: tb/tb_lcb_poll_sched.sv
// tb_lcb_poll_sched: directed frames with randomized byte timing
// checked against a request/timeout reference model.
module tb_lcb_poll_sched;

  localparam int NL = 3;
  localparam int NB = 15;
  localparam int TO = 200;
  localparam int GC = 4;
`ifdef LCB_POLL_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       txReady;
  logic       rxValid;
  logic       txStart;
  logic [7:0] txByte;
  logic [4:0] LCBrqNumber;
  logic       busy;
  logic       frameDone;
  logic       timeoutErr;
  logic [7:0] errCnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_tx  = 0;
  int n_fd  = 0;
  int to_q[$];

  int nbv[NL];
  bit extra[NL];
  bit eto[NL];
  bit hold_rdy;
  bit start_u1;
  bit rst_u2;
  bit did_rst;
  int m_err = 0;
  int exp_tx;
  int exp_to[$];

  `define CHK(tag, o, e) begin total++; assert ((o) === (e)) else begin bad++; $error("FAIL %s: observed=%0h expected=%0h", tag, (o), (e)); end end

  lcb_poll_sched #(
    .NUM_LCB      (NL),
    .BYTES_PER_RQ (NB),
    .TIMEOUT_CYC  (TO),
    .GAP_CYC      (GC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .txReady     (txReady),
    .txStart     (txStart),
    .txByte      (txByte),
    .rxValid     (rxValid),
    .LCBrqNumber (LCBrqNumber),
    .busy        (busy),
    .frameDone   (frameDone),
    .timeoutErr  (timeoutErr),
    .errCnt      (errCnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (txStart === 1'b1) n_tx++;
    if (frameDone === 1'b1) n_fd++;
    if (timeoutErr === 1'b1) to_q.push_back(cyc);
  end

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l);
    rxValid = 1'b1;
    go(h);
    rxValid = 1'b0;
    go(l);
  endtask

  task automatic set_frame(input int a, input int b, input int c);
    nbv[0] = a;
    nbv[1] = b;
    nbv[2] = c;
    for (int i = 0; i < NL; i++) begin
      extra[i] = 1'b0;
      eto[i]   = 1'b0;
    end
    hold_rdy = 1'b0;
    start_u1 = 1'b0;
    rst_u2   = 1'b0;
  endtask

  task automatic wait_tx(input int u, output int t);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (txStart === 1'b1) seen = 1'b1;
    end
    t = cyc;
    `CHK("tx_seen", seen, 1'b1)
    `CHK("tx_byte", txByte, 8'(160 + u))
    `CHK("rq_num", LCBrqNumber, 5'(u))
  endtask

  task automatic serve(input int u, input int t, input bit last);
    int n;
    int base;
    n = nbv[u];
    go(1);
    if (start_u1 && u == 1) begin
      start = 1'b1;
      go(1);
      start = 1'b0;
      `CHK("start_ign_num", LCBrqNumber, 5'd1)
      `CHK("start_ign_busy", busy, 1'b1)
    end
    if (rst_u2 && u == 2) begin
      go(5);
      reset = 1'b1;
      go(1);
      reset = 1'b0;
      `CHK("rst_txStart", txStart, 1'b0)
      `CHK("rst_txByte", txByte, 8'h00)
      `CHK("rst_num", LCBrqNumber, 5'd0)
      `CHK("rst_busy", busy, 1'b0)
      `CHK("rst_frameDone", frameDone, 1'b0)
      `CHK("rst_timeoutErr", timeoutErr, 1'b0)
      `CHK("rst_errCnt", errCnt, 8'h00)
      base = n_tx;
      go(300);
      `CHK("rst_idle_no_tx", n_tx, base)
      m_err = 0;
      did_rst = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (eto[u] && i == n - 1) begin
        go(t + TO - cyc);
        pulse(3, 1);
      end else begin
        pulse($urandom_range(3, 1), $urandom_range(3, 1));
      end
    end
    if (n < NB && last) begin
      exp_to.push_back(t + TO);
      if (m_err < 255) m_err++;
    end
    if (extra[u] && !RETRY) begin
      go(t + TO + 1 - cyc);
      pulse(1, 1);
      pulse(1, 1);
    end
  endtask

  task automatic run_frame();
    int t;
    int tx0;
    int fd0;
    int to0;
    int att;
    int nto;
    tx0 = n_tx;
    fd0 = n_fd;
    to0 = to_q.size();
    exp_to.delete();
    exp_tx  = 0;
    did_rst = 1'b0;
    if (hold_rdy) txReady = 1'b0;
    start = 1'b1;
    go(1);
    start = 1'b0;
    `CHK("busy_after_start", busy, 1'b1)
    if (hold_rdy) begin
      go(50);
      `CHK("rdy_hold_no_tx", n_tx, tx0)
      `CHK("rdy_hold_busy", busy, 1'b1)
      txReady = 1'b1;
    end
    for (int u = 0; u < NL && !did_rst; u++) begin
      att = (nbv[u] < NB && RETRY) ? 2 : 1;
      for (int a = 0; a < att && !did_rst; a++) begin
        wait_tx(u, t);
        exp_tx++;
        serve(u, t, a == att - 1);
      end
    end
    if (did_rst) return;
    for (int k = 0; k < 2000 && n_fd == fd0; k++) @(negedge clk);
    go(2);
    `CHK("frame_done_once", n_fd - fd0, 1)
    `CHK("idle_busy", busy, 1'b0)
    `CHK("num_held", LCBrqNumber, 5'(NL - 1))
    `CHK("tx_count", n_tx - tx0, exp_tx)
    `CHK("err_cnt", errCnt, 8'(m_err))
    nto = to_q.size() - to0;
    `CHK("to_count", nto, exp_to.size())
    for (int i = 0; i < nto && i < exp_to.size(); i++)
      `CHK("to_cycle", to_q[to0 + i], exp_to[i])
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    txReady = 1'b1;
    rxValid = 1'b0;
    go(3);
    `CHK("init_txStart", txStart, 1'b0)
    `CHK("init_txByte", txByte, 8'h00)
    `CHK("init_num", LCBrqNumber, 5'd0)
    `CHK("init_busy", busy, 1'b0)
    `CHK("init_frameDone", frameDone, 1'b0)
    `CHK("init_timeoutErr", timeoutErr, 1'b0)
    `CHK("init_errCnt", errCnt, 8'h00)
    reset = 1'b0;
    go(2);

    set_frame(15, 15, 15);
    run_frame();
    go(5);

    set_frame(15, 10, 15);
    run_frame();
    go(5);

    set_frame(15, 10, 14);
    extra[1] = 1'b1;
    run_frame();
    go(5);

    set_frame(15, 15, 15);
    eto[0]   = 1'b1;
    hold_rdy = 1'b1;
    run_frame();
    go(5);

    set_frame(15, 15, 15);
    start_u1 = 1'b1;
    rst_u2   = 1'b1;
    run_frame();
    `CHK("reset_taken", did_rst, 1'b1)
    go(5);

    set_frame(0, 15, 15);
    run_frame();
    go(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
